// File: rtl/cmp_mask_resolver_if.sv
// Handshake bundle between a compare-result producer and the mask resolver.
// The input side carries one compare result with its branch context. The output
// side carries the resolved branch decision.
interface cmp_mask_resolver_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_mask;
  logic              in_zflag;
  logic [2:0]        in_cond;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_off;
  logic              out_valid;
  logic              out_ready;
  logic              out_taken;
  logic [DATA_W-1:0] out_target;
  logic              out_err;

  // Producer of compare results and consumer of decisions
  modport master (
    output in_valid, in_mask, in_zflag, in_cond, in_pc, in_off, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_err
  );

  // The resolver itself
  modport slave (
    input  in_valid, in_mask, in_zflag, in_cond, in_pc, in_off, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_err
  );
endinterface

// File: rtl/cmp_mask_resolver.sv
// Branch resolver fed by the ALU compare units. It validates the mask and zero flag,
// evaluates the branch condition, and forms the next PC. Each decision goes into a
// 2-entry output buffer whose head register drives the output directly.
// Saturating counters record resolved and taken decisions for debug.
module cmp_mask_resolver #(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  cmp_mask_resolver_if.slave bus,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                head_taken_q;
  logic                head_err_q;
  logic [DATA_W-1:0]   head_target_q;
  logic                tail_taken_q;
  logic                tail_err_q;
  logic [DATA_W-1:0]   tail_target_q;
  logic [CNT_W-1:0]    resolved_q, resolved_d;
  logic [CNT_W-1:0]    taken_q, taken_d;

  logic                mask_set_p0;
  logic                mask_clr_p0;
  logic                err_p0;
  logic                taken_p0;
  logic signed [DATA_W-1:0] off_p0;
  logic [DATA_W-1:0]   fall_p0;
  logic [DATA_W-1:0]   jump_p0;
  logic [DATA_W-1:0]   target_p0;
  logic                push;
  logic                pop;

  function automatic logic cond_eval(input logic [2:0] cond, input logic mset,
                                     input logic mclr, input logic zflag);
    logic t;
    case (cond)
      3'b000:  t = 1'b0;
      3'b001:  t = 1'b1;
      3'b010:  t = mset;
      3'b011:  t = mclr;
      3'b100:  t = zflag;
      3'b101:  t = ~zflag;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // ---- stage p0: combinational decision on the offered compare result ----
  assign mask_set_p0 = (bus.in_mask == '1);
  assign mask_clr_p0 = (bus.in_mask == '0);
  // An illegal mask, a zflag that disagrees with the mask, or a reserved condition
  // all count as malformed. A malformed input never branches.
  assign err_p0      = ~(mask_set_p0 | mask_clr_p0)
                     | (bus.in_zflag != mask_clr_p0)
                     | (bus.in_cond[2:1] == 2'b11);
  assign taken_p0    = ~err_p0 & cond_eval(bus.in_cond, mask_set_p0, mask_clr_p0, bus.in_zflag);
  assign off_p0      = bus.in_off;
  assign fall_p0     = bus.in_pc + DATA_W'(PC_STEP);
  assign jump_p0     = bus.in_pc + DATA_W'($unsigned(off_p0));
  assign target_p0   = taken_p0 ? jump_p0 : fall_p0;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // ---- stage p1: buffered decision (head drives outputs) ----
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_taken  = head_taken_q;
  assign bus.out_target = head_target_q;
  assign bus.out_err    = head_err_q;

  // Buffer occupancy FSM with head entry and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      head_taken_q  <= 1'b0;
      head_err_q    <= 1'b0;
      head_target_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_taken_q  <= taken_p0;
          head_err_q    <= err_p0;
          head_target_q <= target_p0;
          out_valid_q   <= 1'b1;
          state_q       <= ONE;
        end
        ONE: begin
          if (push && pop) begin
            head_taken_q  <= taken_p0;
            head_err_q    <= err_p0;
            head_target_q <= target_p0;
          end else if (push) begin
            in_ready_q    <= 1'b0;
            state_q       <= FULL;
          end else if (pop) begin
            out_valid_q   <= 1'b0;
            state_q       <= EMPTY;
          end
        end
        FULL: if (pop) begin
          head_taken_q  <= tail_taken_q;
          head_err_q    <= tail_err_q;
          head_target_q <= tail_target_q;
          in_ready_q    <= 1'b1;
          state_q       <= ONE;
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  // Second slot captures a new decision only while the head is held
  always_ff @(posedge clk) begin
    if (state_q == ONE && push && !pop) begin
      tail_taken_q  <= taken_p0;
      tail_err_q    <= err_p0;
      tail_target_q <= target_p0;
    end
  end

  assign resolved_d = pop ? sat_inc(resolved_q) : resolved_q;
  assign taken_d    = (pop && head_taken_q) ? sat_inc(taken_q) : taken_q;

  // Debug statistics, advanced only by output handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_q <= '0;
      taken_q    <= '0;
    end else begin
      resolved_q <= resolved_d;
      taken_q    <= taken_d;
    end
  end

  assign resolved_cnt = resolved_q;
  assign taken_cnt    = taken_q;

endmodule

// File: tb/tb_cmp_mask_resolver.sv
// Scoreboard bench for cmp_mask_resolver: a 16-bit counter instance and a
// 2-bit counter instance see identical traffic.
module tb_cmp_mask_resolver;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  logic [15:0] resolved_cnt, taken_cnt;
  logic [1:0]  sat_resolved, sat_taken;

  cmp_mask_resolver_if #(.DATA_W(32)) bus ();
  cmp_mask_resolver_if #(.DATA_W(32)) sat_if ();

  cmp_mask_resolver #(.DATA_W(32), .CNT_W(16), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );

  cmp_mask_resolver #(.DATA_W(32), .CNT_W(2), .PC_STEP(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sat_if.slave),
    .resolved_cnt(sat_resolved), .taken_cnt(sat_taken)
  );

  assign sat_if.in_valid  = bus.in_valid;
  assign sat_if.in_mask   = bus.in_mask;
  assign sat_if.in_zflag  = bus.in_zflag;
  assign sat_if.in_cond   = bus.in_cond;
  assign sat_if.in_pc     = bus.in_pc;
  assign sat_if.in_off    = bus.in_off;
  assign sat_if.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   m_res = 0;
  int   m_tak = 0;
  bit   rnd_on = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic exp_t model(input logic [31:0] m, input logic z, input logic [2:0] c,
                                 input logic [31:0] pc, input logic [31:0] off);
    exp_t e;
    logic t;
    e.err = !((m == 32'hFFFF_FFFF) || (m == 32'h0)) || (z != (m == 32'h0))
          || (c == 3'b110) || (c == 3'b111);
    case (c)
      3'd0: t = 1'b0;
      3'd1: t = 1'b1;
      3'd2: t = (m == 32'hFFFF_FFFF);
      3'd3: t = (m == 32'h0);
      3'd4: t = z;
      3'd5: t = !z;
      default: t = 1'b0;
    endcase
    e.taken  = e.err ? 1'b0 : t;
    e.target = e.taken ? pc + off : pc + 32'd4;
    return e;
  endfunction

  // Output monitor: compares each output handshake and checks hold-while-stalled
  bit          stall_v = 0;
  logic        st_taken, st_err;
  logic [31:0] st_target;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_v = 0;
    end else begin
      if (stall_v && bus.out_valid) begin
        chk("hold_target", bus.out_target, st_target);
        chk("hold_taken", bus.out_taken, st_taken);
        chk("hold_err", bus.out_err, st_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("resolved_cnt", resolved_cnt, m_res);
        chk("taken_cnt", taken_cnt, m_tak);
        chk("sat_resolved_cnt", sat_resolved, sat3(m_res));
        chk("sat_taken_cnt", sat_taken, sat3(m_tak));
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_taken", bus.out_taken, e.taken);
          chk("out_target", bus.out_target, e.target);
          chk("out_err", bus.out_err, e.err);
          m_res++;
          if (e.taken) m_tak++;
        end
        stall_v = 0;
      end else if (bus.out_valid) begin
        stall_v   = 1;
        st_taken  = bus.out_taken;
        st_err    = bus.out_err;
        st_target = bus.out_target;
      end else begin
        stall_v = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] m, input logic z, input logic [2:0] c,
                      input logic [31:0] pc, input logic [31:0] off);
    exp_t e;
    int   n;
    bit   done;
    e = model(m, z, c, pc, off);
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    bus.in_zflag = z;
    bus.in_cond  = c;
    bus.in_pc    = pc;
    bus.in_off   = off;
    done = 0;
    n    = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (!rst && bus.in_ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_res = 0;
    m_tak = 0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_zflag  = 1'b0;
    bus.in_cond   = '0;
    bus.in_pc     = '0;
    bus.in_off    = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_resolved", resolved_cnt, 0);
    chk("rst_taken", taken_cnt, 0);
    chk("rst_target", bus.out_target, 0);
    chk("rst_out_taken", bus.out_taken, 0);
    chk("rst_out_err", bus.out_err, 0);

    // Taken and not-taken with one-cycle latency
    send(32'hFFFF_FFFF, 1'b0, 3'b010, 32'h0000_1000, 32'h0000_0040);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_target", bus.out_target, 32'h0000_1040);
    send(32'h0, 1'b1, 3'b010, 32'h0000_1000, 32'h0000_0040);
    chk("nt_target", bus.out_target, 32'h0000_1004);
    wait_drain();

    // Malformed inputs
    do_reset(1);
    send(32'h0000_FFFF, 1'b0, 3'b001, 32'h0000_2000, 32'h0000_0100);
    send(32'h0, 1'b0, 3'b001, 32'h0000_2000, 32'h0000_0100);
    send(32'hFFFF_FFFF, 1'b0, 3'b111, 32'h0000_2000, 32'h0000_0100);
    wait_drain();
    chk("err_resolved", resolved_cnt, 3);
    chk("err_taken", taken_cnt, 0);

    // Backpressure: third input waits upstream
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'hFFFF_FFFF, 1'b0, 3'b001, 32'h0000_3000, 32'h0000_0010);
        send(32'h0, 1'b1, 3'b100, 32'h0000_3100, 32'h0000_0020);
        send(32'h0, 1'b1, 3'b101, 32'h0000_3200, 32'h0000_0030);
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_held", sb.size(), 2);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait fork;
    wait_drain();
    chk("bp_resolved", resolved_cnt, 6);

    // Address wrap-around, negative offset
    send(32'hFFFF_FFFF, 1'b0, 3'b001, 32'hFFFF_FFF0, 32'h0000_0020);
    send(32'h0, 1'b1, 3'b011, 32'h0000_0008, 32'hFFFF_FFF0);
    send(32'hFFFF_FFFF, 1'b0, 3'b000, 32'hFFFF_FFFE, 32'h0000_0020);
    wait_drain();

    // Saturation of the 2-bit counters after 5 taken decisions
    do_reset(1);
    for (int i = 0; i < 5; i++)
      send(32'hFFFF_FFFF, 1'b0, 3'b001, 32'h0000_4000 + 32'(i * 16), 32'h0000_0080);
    wait_drain();
    chk("sat_taken_final", sat_taken, 3);
    chk("sat_resolved_final", sat_resolved, 3);
    chk("wide_taken_final", taken_cnt, 5);

    // Randomised traffic with toggling out_ready
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      logic [31:0] m;
      case ($urandom_range(0, 3))
        0: m = 32'h0;
        1: m = 32'hFFFF_FFFF;
        2: m = 32'hFFFF_FFFF;
        default: m = $urandom;
      endcase
      send(m, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    rnd_on = 0;
    repeat (3) @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset with a full buffer discards both entries
    bus.out_ready = 1'b0;
    send(32'hFFFF_FFFF, 1'b0, 3'b001, 32'h0000_5000, 32'h0000_0004);
    send(32'h0, 1'b1, 3'b001, 32'h0000_5100, 32'h0000_0004);
    chk("mid_full", bus.in_ready, 0);
    do_reset(1);
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_in_ready", bus.in_ready, 1);
    chk("mid_resolved", resolved_cnt, 0);
    chk("mid_taken", taken_cnt, 0);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_no_emit", bus.out_valid, 0);
    chk("mid_resolved_after", resolved_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_mask_resolver.md
Name: cmp_mask_resolver

Overview:
- Consumer-side stage for the ALU compare units, which emit a 32-bit all-ones/all-zeros result mask plus a zero flag.
- Accepts one compare result per handshake, checks mask/flag consistency and evaluates a branch condition against them.
- Computes the next PC and returns the decision through a 2-entry buffered valid/ready output.
- Keeps saturating counters of resolved and taken decisions for debug readout.

Parameters:
- DATA_W, 32, width of mask, PC, offset and target.
- CNT_W, 16, width of the resolved/taken statistics counters.
- PC_STEP, 4, fall-through increment added to the PC when the branch is not taken.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a compare result.
- in_ready  output  1  stage can accept; high when fewer than 2 entries are held.
- in_mask  input  DATA_W  compare result mask; legal values are all-zeros or all-ones.
- in_zflag  input  1  zero flag from the compare unit; 1 means the mask is all-zeros.
- in_cond  input  3  condition select: 000 never, 001 always, 010 mask set, 011 mask clear, 100 zflag set, 101 zflag clear, 110/111 reserved.
- in_pc  input  DATA_W  PC of the branch.
- in_off  input  DATA_W  branch offset, two's complement.
- out_valid  output  1  a decision is available.
- out_ready  input  1  downstream accepts the decision.
- out_taken  output  1  branch taken.
- out_target  output  DATA_W  next PC.
- out_err  output  1  malformed input, see Behaviour.
- resolved_cnt  output  CNT_W  count of output handshakes.
- taken_cnt  output  CNT_W  count of output handshakes with out_taken=1.

Behaviour:
- Reset (rst=1 at the clk edge):
  - Buffer emptied; out_valid=0; out_taken=0; out_target=0; out_err=0; resolved_cnt=0; taken_cnt=0; in_ready=1 in the following cycle.
  - Reset mid-operation discards held entries; no handshake completes in a reset cycle.
- Input accept: occurs on an edge with in_valid & in_ready.
- Output accept: occurs on an edge with out_valid & out_ready.
- Decision, computed combinationally at input and stored in the buffer:
  - mask_set = (in_mask == all-ones).
  - mask_legal = mask all-ones or all-zeros.
  - consistency error when in_zflag != (in_mask == 0).
  - err = ~mask_legal | consistency error | reserved cond.
  - When err=1: taken forced to 0 and target = in_pc + PC_STEP.
  - Otherwise: taken per in_cond; target = in_pc + in_off if taken, else in_pc + PC_STEP.
  - All additions are modulo 2^DATA_W; wrap-around is silent and is not an error.
- Buffer: 2-entry FIFO, states EMPTY, ONE, FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop together -> ONE, with the new entry becoming head.
  - FULL: in_ready=0; pop -> ONE.
  - in_ready depends only on state, never on out_ready, so there is no combinational path from out_ready to in_ready.
- Latency: 1 cycle. An input accepted at edge N is visible on out_* after edge N, provided the buffer was EMPTY.
- Output stability: out_* hold stable while out_valid=1 and out_ready=0.
- Counters:
  - Both update on output handshake only; an entry with err=1 still counts as resolved.
  - Both saturate at 2^CNT_W-1 and do not wrap.
- No input is dropped. An input presented while FULL waits for in_ready.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, in_ready=1, both counters 0.
- Taken and not-taken branches, out_ready=1:
  - mask=FFFFFFFF, zflag=0, cond=010, pc=00001000, off=00000040 -> next cycle out_taken=1, target=00001040, err=0.
  - mask=0, zflag=1, cond=010, same pc -> taken=0, target=00001004.
- Errors:
  - mask=0000FFFF, cond=001 -> err=1, taken=0, target=pc+4.
  - mask=0, zflag=0 -> err=1.
  - cond=111 -> err=1.
  - After these three, resolved_cnt=3 and taken_cnt=0.
- Backpressure: out_ready=0, push 3 valid inputs back-to-back -> in_ready drops after the 2nd accept, the 3rd is held upstream; release out_ready -> 3 decisions emerge in order, none lost.
- Wrap and saturation:
  - pc=FFFFFFF0, off=00000020, cond=001 -> target=00000010.
  - With CNT_W=2, 5 taken decisions -> taken_cnt=3, resolved_cnt=3.
- Reset mid-operation: buffer FULL, assert rst one cycle -> out_valid=0 next cycle, counters 0, held entries never emitted.
